wb_regfile: RTL and testbench

- Writeback stage plus architectural register file: the consumer end of the MEM/WB pipeline register.
- Selects the writeback value (memory load data or ALU result) and commits it to a 32-entry general-purpose register file.
- Serves the two ID-stage read ports.
- Provides write-through bypass so a same-cycle ID read returns the value being written.

---
 rtl/mips_pkg.sv | 19 +
 rtl/wb_regfile_if.sv | 29 ++
 rtl/regfile_2r1w.sv | 46 ++++
 rtl/wb_regfile.sv | 58 +++++
 tb/tb_wb_regfile.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: datapath/index widths, special register indices,
// and the reset value of the stack pointer.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;

  localparam logic [DATA_W-1:0] SP_INIT = 32'h0000_0FFC;

  // A writeback only lands when enabled and not aimed at the hardwired zero register.
  function automatic logic wb_live(input logic reg_write, input logic [ADDR_W-1:0] dst);
    return reg_write && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-register-file bus: writeback inputs, ID read indices, and the read,
// writeback and forwarding outputs.
interface wb_regfile_if
  import mips_pkg::*;
  ;

  logic              RegWrite;
  logic              MemtoReg;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] ALUresult;
  logic [ADDR_W-1:0] writereg;
  logic [ADDR_W-1:0] readreg1;
  logic [ADDR_W-1:0] readreg2;
  logic [DATA_W-1:0] readdata1;
  logic [DATA_W-1:0] readdata2;
  logic [DATA_W-1:0] wbdata;
  logic              wbvalid;

  modport master (
    output RegWrite, MemtoReg, readdata, ALUresult, writereg, readreg1, readreg2,
    input  readdata1, readdata2, wbdata, wbvalid
  );

  modport slave (
    input  RegWrite, MemtoReg, readdata, ALUresult, writereg, readreg1, readreg2,
    output readdata1, readdata2, wbdata, wbvalid
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register file: one write port, two combinational read ports,
// register 0 hardwired to zero, $sp initialised on reset.
module regfile_2r1w
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];

  // Register array: asynchronous reset to architectural defaults, single write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= (i == int'(REG_SP)) ? SP_INIT : '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Combinational read ports; index 0 never reads the array.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != REG_ZERO) begin
      rdata1 = regs_r[raddr1];
    end else begin
      rdata1 = '0;
    end
    if (raddr2 != REG_ZERO) begin
      rdata2 = regs_r[raddr2];
    end else begin
      rdata2 = '0;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects load vs ALU data, commits it to the register file,
// and bypasses the in-flight write to both ID read ports.
module wb_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  wb_regfile_if.slave bus
);

  logic [DATA_W-1:0] wb_data_s;
  logic              wb_valid_s;
  logic [DATA_W-1:0] rf_rd1_s;
  logic [DATA_W-1:0] rf_rd2_s;

  // Writeback select and commit qualifier.
  always_comb begin
    wb_data_s  = '0;
    wb_valid_s = wb_live(bus.RegWrite, bus.writereg);
    if (bus.MemtoReg) begin
      wb_data_s = bus.readdata;
    end else begin
      wb_data_s = bus.ALUresult;
    end
  end

  regfile_2r1w u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_valid_s),
    .waddr  (bus.writereg),
    .wdata  (wb_data_s),
    .raddr1 (bus.readreg1),
    .raddr2 (bus.readreg2),
    .rdata1 (rf_rd1_s),
    .rdata2 (rf_rd2_s)
  );

  // Same-cycle write-through: wb_valid_s already excludes register 0.
  always_comb begin
    bus.readdata1 = rf_rd1_s;
    bus.readdata2 = rf_rd2_s;
    if (wb_valid_s && (bus.readreg1 == bus.writereg)) begin
      bus.readdata1 = wb_data_s;
    end else begin
      bus.readdata1 = rf_rd1_s;
    end
    if (wb_valid_s && (bus.readreg2 == bus.writereg)) begin
      bus.readdata2 = wb_data_s;
    end else begin
      bus.readdata2 = rf_rd2_s;
    end
  end

  assign bus.wbdata  = wb_data_s;
  assign bus.wbvalid = wb_valid_s;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile: stimulus queues expected output values,
// a monitor process compares them against the live DUT outputs on each sample strobe.
`timescale 1ns/1ps
module tb_wb_regfile;

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_WBV = 2;
  localparam int SEL_WBD = 3;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  wb_regfile_if bus ();

  exp_t sb_q [$];
  event sample_ev;
  int   checks   = 0;
  int   failures = 0;

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: on each strobe, pop every pending expectation and compare to the DUT.
  initial begin
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = sb_q.pop_front();
        case (e.sel)
          SEL_RD1: act = bus.readdata1;
          SEL_RD2: act = bus.readdata2;
          SEL_WBV: act = {31'd0, bus.wbvalid};
          default: act = bus.wbdata;
        endcase
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic flush();
    ->sample_ev;
    #1;
  endtask

  task automatic drive_wb(input logic we, input logic m2r, input logic [4:0] dst,
                          input logic [31:0] ld, input logic [31:0] alu);
    bus.RegWrite  = we;
    bus.MemtoReg  = m2r;
    bus.writereg  = dst;
    bus.readdata  = ld;
    bus.ALUresult = alu;
  endtask

  // Full-cycle write, returning one time unit after the committing edge with RegWrite low.
  task automatic write_reg(input logic [4:0] dst, input logic [31:0] val);
    @(negedge clk);
    drive_wb(1'b1, 1'b0, dst, 32'd0, val);
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_wb(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    bus.readreg1 = 5'd0;
    bus.readreg2 = 5'd0;
    #25;
    @(negedge clk);
    rst_n = 1'b1;

    // Dirty a few registers so the mid-cycle reset is observable.
    write_reg(5'd7, 32'h7777_7777);
    write_reg(5'd29, 32'h0000_1234);
    #1;
    bus.readreg1 = 5'd7;
    bus.readreg2 = 5'd29;
    #1;
    expect_out(SEL_RD1, 32'h7777_7777, "pre_rst_r7");
    expect_out(SEL_RD2, 32'h0000_1234, "pre_rst_r29");
    flush();

    // Asynchronous reset between edges, then sweep every index on both ports.
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out(SEL_RD1, 32'h0000_0000, "async_rst_r7");
    expect_out(SEL_RD2, 32'h0000_0FFC, "async_rst_r29");
    flush();
    for (int i = 0; i < 32; i++) begin
      bus.readreg1 = 5'(i);
      bus.readreg2 = 5'(31 - i);
      #1;
      expect_out(SEL_RD1, (i == 29) ? 32'h0000_0FFC : 32'h0, "rst_sweep_p1");
      expect_out(SEL_RD2, ((31 - i) == 29) ? 32'h0000_0FFC : 32'h0, "rst_sweep_p2");
      flush();
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback select: load data.
    @(negedge clk);
    drive_wb(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 32'h1234_5678);
    bus.readreg1 = 5'd8;
    #2;
    expect_out(SEL_WBD, 32'hDEAD_BEEF, "wbsel_load_wbdata");
    expect_out(SEL_WBV, 32'd1, "wbsel_load_wbvalid");
    flush();
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    expect_out(SEL_RD1, 32'hDEAD_BEEF, "wbsel_load_commit");
    flush();

    // Writeback select: ALU result.
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 5'd8, 32'hDEAD_BEEF, 32'h1234_5678);
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    expect_out(SEL_RD1, 32'h1234_5678, "wbsel_alu_commit");
    flush();

    // Same-cycle bypass on both ports, then old value once the write is withdrawn.
    write_reg(5'd9, 32'h0000_0099);
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 5'd9, 32'd0, 32'hA5A5_0001);
    bus.readreg1 = 5'd9;
    bus.readreg2 = 5'd9;
    #2;
    expect_out(SEL_RD1, 32'hA5A5_0001, "bypass_p1");
    expect_out(SEL_RD2, 32'hA5A5_0001, "bypass_p2");
    flush();
    bus.RegWrite = 1'b0;
    #1;
    expect_out(SEL_RD1, 32'h0000_0099, "nobypass_p1");
    expect_out(SEL_RD2, 32'h0000_0099, "nobypass_p2");
    flush();
    @(posedge clk);
    #1;
    expect_out(SEL_RD1, 32'h0000_0099, "nowrite_r9");
    flush();

    // Zero register ignores writes.
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF);
    bus.readreg1 = 5'd0;
    #2;
    expect_out(SEL_WBV, 32'd0, "r0_wbvalid");
    expect_out(SEL_WBD, 32'hFFFF_FFFF, "r0_wbdata");
    expect_out(SEL_RD1, 32'd0, "r0_pre_edge");
    flush();
    @(posedge clk);
    #1;
    expect_out(SEL_RD1, 32'd0, "r0_post_edge");
    flush();
    bus.RegWrite = 1'b0;

    // Reset mid-operation drops the write presented during reset.
    write_reg(5'd5, 32'h0000_0055);
    bus.readreg1 = 5'd5;
    #1;
    expect_out(SEL_RD1, 32'h0000_0055, "r5_written");
    flush();
    @(negedge clk);
    rst_n = 1'b0;
    drive_wb(1'b1, 1'b0, 5'd5, 32'd0, 32'h0000_0077);
    #2;
    expect_out(SEL_RD1, 32'h0000_0077, "rst_bypass_r5");
    flush();
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    expect_out(SEL_RD1, 32'd0, "rst_dropped_r5");
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expect_out(SEL_RD1, 32'd0, "release_r5");
    flush();
    bus.RegWrite = 1'b1;
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    expect_out(SEL_RD1, 32'h0000_0077, "first_write_after_release");
    flush();

    // Back-to-back writes to reg 3, watched through port 2 via bypass.
    bus.readreg2 = 5'd3;
    for (int v = 1; v <= 3; v++) begin
      @(negedge clk);
      drive_wb(1'b1, 1'b0, 5'd3, 32'd0, 32'(v));
      #2;
      expect_out(SEL_RD2, 32'(v), "b2b_bypass");
      flush();
    end
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    expect_out(SEL_RD2, 32'd3, "b2b_final");
    flush();

    #5;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
